// File: rtl/iob_uart16550_ctrl_pkg.sv
// Shared definitions for the UART16550 controller: FSM encoding, UART register
// offsets, init constants and the init-sequence lookup.
package iob_uart16550_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_INIT    = 2'd0,
    ST_IDLE    = 2'd1,
    ST_GNT     = 2'd2,
    ST_WAIT_RD = 2'd3
  } state_t;

  localparam logic [2:0] UART_RBR = 3'd0;
  localparam logic [2:0] UART_THR = 3'd0;
  localparam logic [2:0] UART_IER = 3'd1;
  localparam logic [2:0] UART_FCR = 3'd2;
  localparam logic [2:0] UART_IIR = 3'd2;
  localparam logic [2:0] UART_LCR = 3'd3;
  localparam logic [2:0] UART_DLL = 3'd0;
  localparam logic [2:0] UART_DLM = 3'd1;

  // LCR with DLAB set and 8N1 framing; FCR enabling and clearing both FIFOs.
  localparam logic [7:0] LCR_DLAB_8N1    = 8'h83;
  localparam logic [7:0] FCR_FIFO_EN_CLR = 8'h07;

  localparam logic [2:0] INIT_LAST_STEP = 3'd4;

  typedef struct packed {
    logic [2:0] addr;
    logic [7:0] data;
  } init_wr_t;

  function automatic init_wr_t init_write(input logic [2:0]  step,
                                          input logic [15:0] divisor,
                                          input logic [7:0]  lcr_val);
    init_wr_t w;
    case (step)
      3'd0:    w = '{addr: UART_LCR, data: LCR_DLAB_8N1};
      3'd1:    w = '{addr: UART_DLL, data: divisor[7:0]};
      3'd2:    w = '{addr: UART_DLM, data: divisor[15:8]};
      3'd3:    w = '{addr: UART_LCR, data: lcr_val};
      default: w = '{addr: UART_FCR, data: FCR_FIFO_EN_CLR};
    endcase
    return w;
  endfunction

endpackage

// File: rtl/iob_rr_arb2.sv
// Two-way round-robin arbiter: on a tie, the host not granted last wins.
module iob_rr_arb2 (
  input  logic       clk_i,
  input  logic       arst_i,
  input  logic       cke_i,
  input  logic [1:0] req,
  input  logic       update,
  output logic [1:0] gnt
);

  logic last_q;  // 1: host 1 was granted last

  always_comb begin
    // NOTE: default assignment first so no path through always_comb infers a latch.
    gnt = req;
    if (&req) gnt = last_q ? 2'b01 : 2'b10;
  end

  always_ff @(posedge clk_i or posedge arst_i) begin
    // NOTE: sequential state uses non-blocking assignments to avoid update-order races.
    if (arst_i)                        last_q <= 1'b1;
    else if (cke_i && update && |gnt)  last_q <= gnt[1];
  end

endmodule

// File: rtl/iob_uart16550_ctrl.sv
// Two-host IOb front end for a UART16550 with optional power-up configuration,
// enabled by defining IOB_UART16550_CTRL_INIT_EN.
module iob_uart16550_ctrl
  import iob_uart16550_ctrl_pkg::*;
#(
  parameter int          ADDR_W  = 5,
  parameter int          DATA_W  = 32,
  parameter logic [15:0] DIVISOR = 16'd27,
  parameter logic [7:0]  LCR_VAL = 8'h03
) (
  input  logic                clk_i,
  input  logic                arst_i,
  input  logic                cke_i,
  input  logic                h0_iob_avalid_i,
  input  logic [ADDR_W-1:0]   h0_iob_addr_i,
  input  logic [DATA_W-1:0]   h0_iob_wdata_i,
  input  logic [DATA_W/8-1:0] h0_iob_wstrb_i,
  output logic                h0_iob_rvalid_o,
  output logic [DATA_W-1:0]   h0_iob_rdata_o,
  output logic                h0_iob_ready_o,
  input  logic                h1_iob_avalid_i,
  input  logic [ADDR_W-1:0]   h1_iob_addr_i,
  input  logic [DATA_W-1:0]   h1_iob_wdata_i,
  input  logic [DATA_W/8-1:0] h1_iob_wstrb_i,
  output logic                h1_iob_rvalid_o,
  output logic [DATA_W-1:0]   h1_iob_rdata_o,
  output logic                h1_iob_ready_o,
  output logic                m_iob_avalid_o,
  output logic [ADDR_W-1:0]   m_iob_addr_o,
  output logic [DATA_W-1:0]   m_iob_wdata_o,
  output logic [DATA_W/8-1:0] m_iob_wstrb_o,
  input  logic                m_iob_rvalid_i,
  input  logic [DATA_W-1:0]   m_iob_rdata_i,
  input  logic                m_iob_ready_i,
  output logic                init_done_o
);

  localparam int STRB_W = DATA_W / 8;

  state_t              state_q, state_d;
  logic                owner_q;
  logic [1:0]          arb_req, arb_gnt;
  logic                sel, active;
  logic                sel_avalid, sel_is_wr;
  logic [ADDR_W-1:0]   sel_addr;
  logic [DATA_W-1:0]   sel_wdata;
  logic [STRB_W-1:0]   sel_wstrb;
  logic                init_last;
  logic [ADDR_W-1:0]   init_addr;
  logic [DATA_W-1:0]   init_wdata;
  logic [STRB_W-1:0]   init_wstrb;

`ifdef IOB_UART16550_CTRL_INIT_EN
  localparam state_t RST_STATE = ST_INIT;
  logic [2:0] step_q;
  init_wr_t   init_wr;

  // Each init byte sits on lane addr%4 of the data bus.
  assign init_wr     = init_write(step_q, DIVISOR, LCR_VAL);
  assign init_addr   = ADDR_W'(init_wr.addr);
  assign init_wdata  = DATA_W'(init_wr.data) << {init_wr.addr[1:0], 3'b000};
  assign init_wstrb  = STRB_W'(1) << init_wr.addr[1:0];
  assign init_last   = (step_q == INIT_LAST_STEP);
  assign init_done_o = (state_q != ST_INIT);

  always_ff @(posedge clk_i or posedge arst_i) begin
    if (arst_i)
      step_q <= 3'd0;
    else if (cke_i && state_q == ST_INIT && m_iob_ready_i)
      step_q <= init_last ? 3'd0 : step_q + 3'd1;
  end
`else
  localparam state_t RST_STATE = ST_IDLE;
  logic unused_cfg;

  assign unused_cfg  = ^{DIVISOR, LCR_VAL};
  assign init_addr   = '0;
  assign init_wdata  = '0;
  assign init_wstrb  = '0;
  assign init_last   = 1'b0;
  assign init_done_o = 1'b1;
`endif

  // Arbitration only happens in IDLE; afterwards the owner is held in owner_q.
  assign arb_req = (state_q == ST_IDLE) ? {h1_iob_avalid_i, h0_iob_avalid_i} : 2'b00;

  iob_rr_arb2 u_arb (
    .clk_i  (clk_i),
    .arst_i (arst_i),
    .cke_i  (cke_i),
    .req    (arb_req),
    .update (|arb_gnt),
    .gnt    (arb_gnt)
  );

  assign sel        = (state_q == ST_IDLE) ? arb_gnt[1] : owner_q;
  assign active     = (state_q == ST_IDLE) ? |arb_gnt : (state_q == ST_GNT);
  assign sel_avalid = sel ? h1_iob_avalid_i : h0_iob_avalid_i;
  assign sel_addr   = sel ? h1_iob_addr_i   : h0_iob_addr_i;
  assign sel_wdata  = sel ? h1_iob_wdata_i  : h0_iob_wdata_i;
  assign sel_wstrb  = sel ? h1_iob_wstrb_i  : h0_iob_wstrb_i;
  assign sel_is_wr  = |sel_wstrb;

  always_ff @(posedge clk_i or posedge arst_i) begin
    if (arst_i) begin
      state_q <= RST_STATE;
      owner_q <= 1'b0;
    end else if (cke_i) begin
      state_q <= state_d;
      if (state_q == ST_IDLE && active) owner_q <= sel;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_INIT:
        if (m_iob_ready_i && init_last) state_d = ST_IDLE;
      ST_IDLE, ST_GNT:
        if (active) begin
          if (!sel_avalid)        state_d = ST_IDLE;
          else if (m_iob_ready_i) state_d = sel_is_wr ? ST_IDLE : ST_WAIT_RD;
          else                    state_d = ST_GNT;
        end
      ST_WAIT_RD:
        if (m_iob_rvalid_i) state_d = ST_IDLE;
      default:
        state_d = RST_STATE;
    endcase
  end

  // Outputs are forced low while reset is asserted, whatever the hosts drive.
  always_comb begin
    m_iob_avalid_o  = 1'b0;
    m_iob_addr_o    = '0;
    m_iob_wdata_o   = '0;
    m_iob_wstrb_o   = '0;
    h0_iob_ready_o  = 1'b0;
    h1_iob_ready_o  = 1'b0;
    h0_iob_rvalid_o = 1'b0;
    h1_iob_rvalid_o = 1'b0;
    h0_iob_rdata_o  = '0;
    h1_iob_rdata_o  = '0;
    if (!arst_i) begin
      case (state_q)
        ST_INIT: begin
          m_iob_avalid_o = 1'b1;
          m_iob_addr_o   = init_addr;
          m_iob_wdata_o  = init_wdata;
          m_iob_wstrb_o  = init_wstrb;
        end
        ST_IDLE, ST_GNT:
          if (active) begin
            m_iob_avalid_o = sel_avalid;
            m_iob_addr_o   = sel_addr;
            m_iob_wdata_o  = sel_wdata;
            m_iob_wstrb_o  = sel_wstrb;
            if (sel) h1_iob_ready_o = m_iob_ready_i;
            else     h0_iob_ready_o = m_iob_ready_i;
          end
        ST_WAIT_RD:
          if (owner_q) begin
            h1_iob_rvalid_o = m_iob_rvalid_i;
            h1_iob_rdata_o  = m_iob_rdata_i;
          end else begin
            h0_iob_rvalid_o = m_iob_rvalid_i;
            h0_iob_rdata_o  = m_iob_rdata_i;
          end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_iob_uart16550_ctrl.sv
// Directed bench for iob_uart16550_ctrl with a master-side and read-return scoreboard.
module tb_iob_uart16550_ctrl;

  logic        clk_i, arst_i, cke_i;
  logic        h0_iob_avalid_i, h1_iob_avalid_i;
  logic [4:0]  h0_iob_addr_i, h1_iob_addr_i;
  logic [31:0] h0_iob_wdata_i, h1_iob_wdata_i;
  logic [3:0]  h0_iob_wstrb_i, h1_iob_wstrb_i;
  logic        h0_iob_rvalid_o, h1_iob_rvalid_o, h0_iob_ready_o, h1_iob_ready_o;
  logic [31:0] h0_iob_rdata_o, h1_iob_rdata_o;
  logic        m_iob_avalid_o, m_iob_rvalid_i, m_iob_ready_i;
  logic [4:0]  m_iob_addr_o;
  logic [31:0] m_iob_wdata_o, m_iob_rdata_i;
  logic [3:0]  m_iob_wstrb_o;
  logic        init_done_o;

  iob_uart16550_ctrl dut (
    .clk_i(clk_i), .arst_i(arst_i), .cke_i(cke_i),
    .h0_iob_avalid_i(h0_iob_avalid_i), .h0_iob_addr_i(h0_iob_addr_i),
    .h0_iob_wdata_i(h0_iob_wdata_i), .h0_iob_wstrb_i(h0_iob_wstrb_i),
    .h0_iob_rvalid_o(h0_iob_rvalid_o), .h0_iob_rdata_o(h0_iob_rdata_o),
    .h0_iob_ready_o(h0_iob_ready_o),
    .h1_iob_avalid_i(h1_iob_avalid_i), .h1_iob_addr_i(h1_iob_addr_i),
    .h1_iob_wdata_i(h1_iob_wdata_i), .h1_iob_wstrb_i(h1_iob_wstrb_i),
    .h1_iob_rvalid_o(h1_iob_rvalid_o), .h1_iob_rdata_o(h1_iob_rdata_o),
    .h1_iob_ready_o(h1_iob_ready_o),
    .m_iob_avalid_o(m_iob_avalid_o), .m_iob_addr_o(m_iob_addr_o),
    .m_iob_wdata_o(m_iob_wdata_o), .m_iob_wstrb_o(m_iob_wstrb_o),
    .m_iob_rvalid_i(m_iob_rvalid_i), .m_iob_rdata_i(m_iob_rdata_i),
    .m_iob_ready_i(m_iob_ready_i),
    .init_done_o(init_done_o)
  );

  typedef struct {
    logic [4:0]  addr;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
  } mtxn_t;

  typedef struct {
    logic        host;
    logic [31:0] data;
  } rd_t;

  mtxn_t exp_m[$];
  rd_t   exp_rd[$];
  mtxn_t mon_m;
  rd_t   mon_r;
  int    n_checks = 0;
  int    n_fail   = 0;

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic push_m(input logic [4:0] a, input logic [31:0] d, input logic [3:0] s);
    mtxn_t t;
    t.addr = a; t.wdata = d; t.wstrb = s;
    exp_m.push_back(t);
  endtask

  task automatic push_rd(input logic h, input logic [31:0] d);
    rd_t r;
    r.host = h; r.data = d;
    exp_rd.push_back(r);
  endtask

  task automatic idle_inputs();
    cke_i = 1'b1;
    h0_iob_avalid_i = 1'b0; h0_iob_addr_i = '0; h0_iob_wdata_i = '0; h0_iob_wstrb_i = '0;
    h1_iob_avalid_i = 1'b0; h1_iob_addr_i = '0; h1_iob_wdata_i = '0; h1_iob_wstrb_i = '0;
    m_iob_rvalid_i = 1'b0; m_iob_rdata_i = '0; m_iob_ready_i = 1'b0;
  endtask

  task automatic host_drive(input logic h, input logic v, input logic [4:0] a,
                            input logic [31:0] d, input logic [3:0] s);
    if (h) begin
      h1_iob_avalid_i = v; h1_iob_addr_i = a; h1_iob_wdata_i = d; h1_iob_wstrb_i = s;
    end else begin
      h0_iob_avalid_i = v; h0_iob_addr_i = a; h0_iob_wdata_i = d; h0_iob_wstrb_i = s;
    end
  endtask

  task automatic check_outputs_zero(input string tag);
    check({tag, "_m_avalid"}, m_iob_avalid_o, 0);
    check({tag, "_m_wdata"},  m_iob_wdata_o, 0);
    check({tag, "_ready"},    {h1_iob_ready_o, h0_iob_ready_o}, 0);
    check({tag, "_rvalid"},   {h1_iob_rvalid_o, h0_iob_rvalid_o}, 0);
  endtask

`ifdef IOB_UART16550_CTRL_INIT_EN
  task automatic push_init();
    push_m(5'd3, 32'h8300_0000, 4'b1000);
    push_m(5'd0, 32'h0000_001B, 4'b0001);
    push_m(5'd1, 32'h0000_0000, 4'b0010);
    push_m(5'd3, 32'h0300_0000, 4'b1000);
    push_m(5'd2, 32'h0007_0000, 4'b0100);
  endtask

  task automatic wait_init_done();
    for (int i = 0; i < 50 && !init_done_o; i++) tick();
    check("init_done", init_done_o, 1);
  endtask
`endif

  task automatic do_reset();
    idle_inputs();
    arst_i = 1'b1;
    #1;
    check_outputs_zero("reset");
`ifdef IOB_UART16550_CTRL_INIT_EN
    check("reset_init_done", init_done_o, 0);
`else
    check("reset_init_done_tied", init_done_o, 1);
`endif
    tick();
    tick();
`ifdef IOB_UART16550_CTRL_INIT_EN
    push_init();
    m_iob_ready_i = 1'b1;
    arst_i = 1'b0;
    tick();
    check("init_busy_ready", {h1_iob_ready_o, h0_iob_ready_o}, 0);
    wait_init_done();
    m_iob_ready_i = 1'b0;
`else
    arst_i = 1'b0;
    #1;
    check("init_done_tied", init_done_o, 1);
`endif
  endtask

  // Scoreboard: every master handshake and every host read return is popped here.
  always @(negedge clk_i) begin
    if (!arst_i) begin
      if (m_iob_avalid_o && m_iob_ready_i) begin
        check("m_txn_expected", exp_m.size() != 0, 1);
        if (exp_m.size() != 0) begin
          mon_m = exp_m.pop_front();
          check("m_addr",  m_iob_addr_o,  mon_m.addr);
          check("m_wdata", m_iob_wdata_o, mon_m.wdata);
          check("m_wstrb", m_iob_wstrb_o, mon_m.wstrb);
        end
      end
      if (h0_iob_rvalid_o || h1_iob_rvalid_o) begin
        check("rd_expected", exp_rd.size() != 0, 1);
        if (exp_rd.size() != 0) begin
          mon_r = exp_rd.pop_front();
          check("rd_route", {h1_iob_rvalid_o, h0_iob_rvalid_o}, mon_r.host ? 2'b10 : 2'b01);
          check("rd_rdata", mon_r.host ? h1_iob_rdata_o : h0_iob_rdata_o, mon_r.data);
          check("rd_other_rdata", mon_r.host ? h0_iob_rdata_o : h1_iob_rdata_o, 0);
        end
      end
    end
  end

  initial begin
    arst_i = 1'b1;
    idle_inputs();
    do_reset();

    // First host write after reset goes straight through.
    m_iob_ready_i = 1'b1;
    host_drive(0, 1, 5'd0, 32'h0000_0041, 4'b0001);
    push_m(5'd0, 32'h0000_0041, 4'b0001);
    #1;
    check("wr0_h0_ready", h0_iob_ready_o, 1);
    check("wr0_h1_ready", h1_iob_ready_o, 0);
    check("wr0_m_avalid", m_iob_avalid_o, 1);
    tick();
    host_drive(0, 0, 5'd0, 32'h0, 4'b0000);

    // Host-0 read, UART answers two cycles after acceptance.
    host_drive(0, 1, 5'd5, 32'h0, 4'b0000);
    push_m(5'd5, 32'h0, 4'b0000);
    tick();
    host_drive(0, 0, 5'd0, 32'h0, 4'b0000);
    #1;
    check("rd_wait_h0_ready", h0_iob_ready_o, 0);
    tick();
    tick();
    m_iob_rvalid_i = 1'b1;
    m_iob_rdata_i  = 32'h60;
    push_rd(0, 32'h60);
    #1;
    check("rd_h0_rvalid", h0_iob_rvalid_o, 1);
    check("rd_h1_rvalid", h1_iob_rvalid_o, 0);
    tick();
    m_iob_rvalid_i = 1'b0;
    m_iob_rdata_i  = '0;

    // Both hosts write back to back: grants alternate starting with host 0.
    do_reset();
    m_iob_ready_i = 1'b1;
    host_drive(0, 1, 5'd0, 32'h0000_00A0, 4'b0001);
    host_drive(1, 1, 5'd1, 32'h0000_B100, 4'b0010);
    for (int i = 0; i < 4; i++) begin
      if (i % 2 == 0) push_m(5'd0, 32'h0000_00A0, 4'b0001);
      else            push_m(5'd1, 32'h0000_B100, 4'b0010);
      #1;
      check("rr_h0_ready", h0_iob_ready_o, (i % 2 == 0));
      check("rr_h1_ready", h1_iob_ready_o, (i % 2 == 1));
      tick();
    end
    host_drive(0, 0, 5'd0, 32'h0, 4'b0000);
    host_drive(1, 0, 5'd0, 32'h0, 4'b0000);

    // Host-1 read outstanding blocks host 0 until the cycle after rvalid.
    host_drive(1, 1, 5'd2, 32'h0, 4'b0000);
    push_m(5'd2, 32'h0, 4'b0000);
    tick();
    host_drive(1, 0, 5'd0, 32'h0, 4'b0000);
    host_drive(0, 1, 5'd3, 32'h5500_0000, 4'b1000);
    #1;
    check("blk_h0_ready_0", h0_iob_ready_o, 0);
    tick();
    check("blk_h0_ready_1", h0_iob_ready_o, 0);
    m_iob_rvalid_i = 1'b1;
    m_iob_rdata_i  = 32'h0000_1234;
    push_rd(1, 32'h0000_1234);
    #1;
    check("blk_h0_ready_rv", h0_iob_ready_o, 0);
    push_m(5'd3, 32'h5500_0000, 4'b1000);
    tick();
    m_iob_rvalid_i = 1'b0;
    m_iob_rdata_i  = '0;
    #1;
    check("blk_h0_granted", h0_iob_ready_o, 1);
    tick();
    host_drive(0, 0, 5'd0, 32'h0, 4'b0000);

    // A host that withdraws before acceptance loses its grant.
    m_iob_ready_i = 1'b0;
    host_drive(0, 1, 5'd0, 32'h0000_0011, 4'b0001);
    #1;
    check("lose_m_avalid", m_iob_avalid_o, 1);
    tick();
    host_drive(0, 0, 5'd0, 32'h0, 4'b0000);
    host_drive(1, 1, 5'd1, 32'h0000_2200, 4'b0010);
    #1;
    check("lose_dropped_avalid", m_iob_avalid_o, 0);
    check("lose_h1_blocked", h1_iob_ready_o, 0);
    tick();
    m_iob_ready_i = 1'b1;
    push_m(5'd1, 32'h0000_2200, 4'b0010);
    #1;
    check("lose_h1_granted", h1_iob_ready_o, 1);
    tick();
    host_drive(1, 0, 5'd0, 32'h0, 4'b0000);

`ifdef IOB_UART16550_CTRL_INIT_EN
    // Reset in the middle of the DLM write restarts the sequence.
    idle_inputs();
    arst_i = 1'b1;
    tick();
    push_init();
    m_iob_ready_i = 1'b1;
    arst_i = 1'b0;
    tick();
    tick();
    m_iob_ready_i = 1'b0;
    #1;
    check("dlm_addr", m_iob_addr_o, 5'd1);
    check("dlm_wstrb", m_iob_wstrb_o, 4'b0010);
    arst_i = 1'b1;
    #1;
    check_outputs_zero("midinit_reset");
    check("midinit_init_done", init_done_o, 0);
    exp_m.delete();
    push_init();
    tick();
    m_iob_ready_i = 1'b1;
    arst_i = 1'b0;
    wait_init_done();
    m_iob_ready_i = 1'b0;
`endif

    tick();
    check("m_queue_drained", exp_m.size(), 0);
    check("rd_queue_drained", exp_rd.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/iob_uart16550_ctrl.md
IOB_UART16550_CTRL -- requirements
Module: iob_uart16550_ctrl

Interface
REQ-001 SHALL have parameter ADDR_W, default 5, UART register address width.
REQ-002 SHALL have parameter DATA_W, default 32, IOb data width.
REQ-003 SHALL have parameter DIVISOR, default 16'd27, baud divisor programmed at init.
REQ-004 SHALL have parameter LCR_VAL, default 8'h03 (8N1), final line-control value.
REQ-005 SHALL have one clock and an asynchronous active-high reset, as listed:
- clk_i  in  1  clock
- arst_i  in  1  asynchronous active-high reset
- cke_i  in  1  clock enable; state frozen when low
REQ-006 SHALL have the host-0 IOb slave port:
- h0_iob_avalid_i  in  1
- h0_iob_addr_i  in  ADDR_W
- h0_iob_wdata_i  in  DATA_W
- h0_iob_wstrb_i  in  DATA_W/8
- h0_iob_rvalid_o  out  1
- h0_iob_rdata_o  out  DATA_W
- h0_iob_ready_o  out  1
REQ-007 SHALL have the host-1 IOb slave port, named identically with prefix h1_.
REQ-008 SHALL have the IOb master port to the UART:
- m_iob_avalid_o  out  1
- m_iob_addr_o  out  ADDR_W
- m_iob_wdata_o  out  DATA_W
- m_iob_wstrb_o  out  DATA_W/8
- m_iob_rvalid_i  in  1
- m_iob_rdata_i  in  DATA_W
- m_iob_ready_i  in  1
REQ-009 SHALL have init_done_o  out  1, high once the UART is configured.

Function
REQ-010 SHALL implement FSM states INIT, IDLE, GNT, WAIT_RD.
REQ-011 INIT SHALL issue five byte writes in order, each held until m_iob_ready_i:
- LCR(3) = 0x83
- DLL(0) = DIVISOR[7:0]
- DLM(1) = DIVISOR[15:8]
- LCR(3) = LCR_VAL
- FCR(2) = 0x07
REQ-012 Each init write SHALL place its byte on lane addr%4 (wdata shifted 8*(addr%4)) and set wstrb = 1<<(addr%4).
REQ-013 After the fifth accepted write, SHALL enter IDLE and set init_done_o the next cycle.
REQ-014 During INIT, both hosts' ready_o and rvalid_o SHALL be 0.
REQ-015 In IDLE, a request on one host SHALL be granted that cycle and its signals passed combinationally to the master port.
- Simultaneous requests are resolved round-robin, favouring the host not granted last.
- Host 0 wins the first tie after reset.
REQ-016 The granted host's ready_o SHALL equal m_iob_ready_i; the non-granted host's ready_o SHALL be 0.
REQ-017 Grant SHALL be released when the transaction completes:
- write (wstrb != 0): on avalid&ready;
- read: the FSM enters WAIT_RD on acceptance, and the grant is held until m_iob_rvalid_i.
REQ-018 m_iob_rdata_i and m_iob_rvalid_i SHALL route only to the host that issued the read.
REQ-019 Only one transaction SHALL be outstanding; a new grant is allowed the cycle after rvalid.
REQ-020 A host deasserting avalid before acceptance SHALL lose its grant; the FSM returns to IDLE with no master transaction.

Reset
REQ-021 On arst_i, SHALL immediately force:
- state = INIT, or IDLE when the init macro is absent;
- init step 0;
- last-grant = host 1;
- all outputs 0.
REQ-022 Reset during INIT or WAIT_RD SHALL abandon the transaction; the sequence restarts from step 0.

Configuration
REQ-023 Macro IOB_UART16550_CTRL_INIT_EN:
- defined: INIT sequence present;
- undefined: reset enters IDLE, init_done_o is tied 1, and DIVISOR and LCR_VAL are unused.

Structure
REQ-024 State encodings, UART register offsets (RBR/THR=0, IER=1, FCR/IIR=2, LCR=3, DLL=0, DLM=1) and the 0x83/0x07 constants SHALL live in shared header iob_uart16550_ctrl_defs.vh.
REQ-025 Two-way round-robin grant logic SHALL be sub-module iob_rr_arb2 (inputs req[1:0] and update; output gnt[1:0]).

Verification
REQ-026 Reset release, DIVISOR=27, m_iob_ready_i=1 -> five writes (addr,wstrb,wdata) SHALL appear in order:
- (3,4'b1000,0x83000000)
- (0,4'b0001,0x1B)
- (1,4'b0010,0x00)
- (3,4'b1000,0x03000000)
- (2,4'b0100,0x00070000)
- then init_done_o=1.
REQ-027 Host-0 read at addr 5, UART rvalid 2 cycles later with rdata 0x60 -> h0_iob_rvalid_o=1 with 0x60; h1 sees no rvalid.
REQ-028 Both hosts write continuously -> grants SHALL alternate h0,h1,h0,h1 across 4 transactions.
REQ-029 Host-1 read outstanding while host-0 requests -> h0_iob_ready_o=0 until the cycle after rvalid, then h0 is granted.
REQ-030 arst_i pulsed during the DLM write -> all outputs 0; the sequence restarts with the LCR=0x83 write.
REQ-031 Build without IOB_UART16550_CTRL_INIT_EN -> init_done_o=1 from reset; the first host write passes through the same cycle.
